row_window_ctrl: RTL and testbench

//   Upstream feeder for the 3x3 window selector. Streams image pixels in

---
 rtl/row_window_ctrl.sv | 167 ++++++++++++++++
 tb/tb_row_window_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_window_ctrl.sv
// rtl/row_window_ctrl.sv - row-buffer feeder for the 3x3 window selector
// Fills three rotating row registers in raster order and sweeps one window per handshake.
module row_window_ctrl #(
  parameter int PIX_W = 12,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [IMG_W*PIX_W-1:0] rdata0,
  output logic [IMG_W*PIX_W-1:0] rdata1,
  output logic [IMG_W*PIX_W-1:0] rdata2,
  output logic [2:0]             reg_sel,
  output logic [7:0]             col_cnt,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [7:0]             win_row,
  output logic                   frame_done
);

  localparam int RW = IMG_W * PIX_W;
  localparam int LW = $clog2(RW);
  localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SWEEP, S_ZERO, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [RW-1:0]   r_line0;
  logic [RW-1:0]   r_line1;
  logic [RW-1:0]   r_line2;
  logic [2:0]      r_sel;
  logic [7:0]      r_col;
  logic [7:0]      r_win_row;
  logic [1:0]      r_tgt;
  logic            r_init;

  logic            w_xfer;
  logic            w_hs;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_more_rows;
  logic [LW-1:0]   w_lsb;
  logic [1:0]      w_old_top;

  assign w_xfer      = pix_valid && (r_state == S_LOAD);
  assign w_hs        = win_ready && (r_state == S_SWEEP);
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_win_row == LAST_ROW);
  // true when the row below the next centre row still exists in the image
  assign w_more_rows = ({24'd0, r_win_row} + 32'd2) < 32'(IMG_H);
  assign w_lsb       = LW'(r_col) * LW'(PIX_W);
  assign w_old_top   = r_sel[2] ? 2'd0 : (r_sel[0] ? 2'd1 : 2'd2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    pix_ready  = 1'b0;
    win_valid  = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_LOAD;
      S_LOAD: begin
        pix_ready = 1'b1;
        if (w_xfer && w_last_col && !r_init) w_next = S_SWEEP;
      end
      S_SWEEP: begin
        win_valid = 1'b1;
        if (w_hs && w_last_col) begin
          if (w_last_row)       w_next = S_DONE;
          else if (w_more_rows) w_next = S_LOAD;
          else                  w_next = S_ZERO;
        end
      end
      S_ZERO: w_next = S_SWEEP;
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line0   <= '0;
      r_line1   <= '0;
      r_line2   <= '0;
      r_sel     <= 3'b000;
      r_col     <= 8'd0;
      r_win_row <= 8'd0;
      r_tgt     <= 2'd0;
      r_init    <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_line0   <= '0;
          r_line1   <= '0;
          r_line2   <= '0;
          r_sel     <= 3'b100;
          r_win_row <= 8'd0;
          r_col     <= 8'd0;
          r_tgt     <= 2'd1;
          r_init    <= 1'b1;
        end
        S_LOAD: if (w_xfer) begin
          case (r_tgt)
            2'd0:    r_line0[w_lsb +: PIX_W] <= pix_in;
            2'd1:    r_line1[w_lsb +: PIX_W] <= pix_in;
            default: r_line2[w_lsb +: PIX_W] <= pix_in;
          endcase
          if (w_last_col) begin
            r_col <= 8'd0;
            // the initial fill loads two rows back to back before sweeping
            if (r_init) begin
              r_tgt  <= 2'd2;
              r_init <= 1'b0;
            end
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        S_SWEEP: if (w_hs) begin
          if (w_last_col) begin
            r_col <= 8'd0;
            if (!w_last_row) begin
              r_win_row <= r_win_row + 8'd1;
              r_sel     <= {r_sel[1:0], r_sel[2]};
              r_tgt     <= w_old_top;
            end
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        S_ZERO: begin
          case (r_tgt)
            2'd0:    r_line0 <= '0;
            2'd1:    r_line1 <= '0;
            default: r_line2 <= '0;
          endcase
        end
        S_DONE: r_sel <= 3'b000;
        default: ;
      endcase
    end
  end

  assign rdata0  = r_line0;
  assign rdata1  = r_line1;
  assign rdata2  = r_line2;
  assign reg_sel = r_sel;
  assign col_cnt = r_col;
  assign win_row = r_win_row;

endmodule

// File: tb/tb_row_window_ctrl.sv
// tb/tb_row_window_ctrl.sv - self-checking bench for row_window_ctrl
// Image-level window model plus directed checks for fill, stall, rotation, bottom edge and reset.
module tb_row_window_ctrl;

  localparam int PIX_W = 12;
  localparam int IMG_W = 256;
  localparam int IMG_H = 4;
  localparam int RW    = IMG_W * PIX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [RW-1:0]    rdata0;
  logic [RW-1:0]    rdata1;
  logic [RW-1:0]    rdata2;
  logic [2:0]       reg_sel;
  logic [7:0]       col_cnt;
  logic             win_valid;
  logic             win_ready;
  logic [7:0]       win_row;
  logic             frame_done;

  int errors = 0;
  int checks = 0;
  int pidx   = 0;
  logic [RW-1:0] rows_exp [0:IMG_H+1];

  row_window_ctrl #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
    .reg_sel(reg_sel), .col_cnt(col_cnt), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] pix_of(input int idx);
    int r;
    int c;
    r = idx / IMG_W;
    c = idx % IMG_W;
    return PIX_W'((r << 8) + c + 1);
  endfunction

  function automatic logic [2:0] sel_of(input int row);
    case (row % 3)
      0:       return 3'b100;
      1:       return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic x;
    x = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    if (x && !rst) pidx++;
    pix_in = pix_of(pidx);
  endtask

  // image-level model: window number hs -> centre row/col, rows above/below zero padded
  int hs = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    logic [RW-1:0] top;
    logic [RW-1:0] mid;
    logic [RW-1:0] bot;
    int row;
    int col;
    if (rst) begin
      hs = 0;
      prev_done = 1'b0;
    end else begin
      check("ready_valid_exclusive", 64'(pix_ready & win_valid), 64'd0);
      if (prev_done) begin
        check("done_single_pulse", 64'(frame_done), 64'd0);
        check("sel_after_done", 64'(reg_sel), 64'd0);
      end
      if (win_valid) begin
        row = hs / IMG_W;
        col = hs % IMG_W;
        check("model_win_row", 64'(win_row), 64'(row));
        check("model_col_cnt", 64'(col_cnt), 64'(col));
        check("model_reg_sel", 64'(reg_sel), 64'(sel_of(row)));
        case (reg_sel)
          3'b100:  begin top = rdata0; mid = rdata1; bot = rdata2; end
          3'b001:  begin top = rdata1; mid = rdata2; bot = rdata0; end
          3'b010:  begin top = rdata2; mid = rdata0; bot = rdata1; end
          default: begin top = '1;     mid = '1;     bot = '1;     end
        endcase
        if (row < IMG_H) begin
          check("model_top_row", 64'(top == rows_exp[row]), 64'd1);
          check("model_mid_row", 64'(mid == rows_exp[row+1]), 64'd1);
          check("model_bot_row", 64'(bot == rows_exp[row+2]), 64'd1);
        end else begin
          check("model_extra_window", 64'(row), 64'(IMG_H - 1));
        end
        if (win_ready) hs = hs + 1;
      end
      if (frame_done) begin
        check("model_windows_per_frame", 64'(hs), 64'(IMG_W * IMG_H));
        hs = 0;
      end
      prev_done = frame_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [RW-1:0] s0;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;

    rows_exp[0]       = '0;
    rows_exp[IMG_H+1] = '0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        rows_exp[r+1][c*PIX_W +: PIX_W] = pix_of(r * IMG_W + c);

    rst = 1'b1; start = 1'b0; pix_valid = 1'b1; win_ready = 1'b1; pix_in = pix_of(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_pix_ready", 64'(pix_ready), 64'd0);
      check("idle_reg_sel", 64'(reg_sel), 64'd0);
      check("idle_win_valid", 64'(win_valid), 64'd0);
      check("idle_col_cnt", 64'(col_cnt), 64'd0);
      check("idle_frame_done", 64'(frame_done), 64'd0);
    end

    start = 1'b1; step(); start = 1'b0;
    lat = 0;
    while (!win_valid && lat < 600) begin step(); lat++; end
    check("fill_latency", 64'(lat), 64'd513);
    check("fill_r1_c0", 64'(rdata1[0 +: PIX_W]), 64'h001);
    check("fill_r2_c255", 64'(rdata2[255*PIX_W +: PIX_W]), 64'h200);
    check("fill_r0_zero", 64'(rdata0 == '0), 64'd1);
    check("fill_reg_sel", 64'(reg_sel), 64'b100);
    check("fill_col0", 64'(col_cnt), 64'd0);

    n = 0;
    while (col_cnt != 8'd7 && n < 20) begin step(); n++; end
    check("bp_reach_col7", 64'(col_cnt), 64'd7);
    win_ready = 1'b0;
    s0 = rdata0; s1 = rdata1; s2 = rdata2;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_col_hold", 64'(col_cnt), 64'd7);
      check("bp_rows_stable", 64'(rdata0 == s0 && rdata1 == s1 && rdata2 == s2), 64'd1);
      check("bp_valid_held", 64'(win_valid), 64'd1);
    end
    win_ready = 1'b1;
    step();
    check("bp_release_col8", 64'(col_cnt), 64'd8);

    n = 0;
    while (reg_sel != 3'b001 && n < 300) begin step(); n++; end
    check("rot1_reg_sel", 64'(reg_sel), 64'b001);
    check("rot1_win_row", 64'(win_row), 64'd1);
    check("rot1_loading", 64'(pix_ready), 64'd1);
    n = 0;
    while (!win_valid && n < 300) begin step(); n++; end
    check("rot1_r0_c0", 64'(rdata0[0 +: PIX_W]), 64'h201);
    check("rot1_r0_c255", 64'(rdata0[255*PIX_W +: PIX_W]), 64'h300);
    n = 0;
    while (reg_sel != 3'b010 && n < 600) begin step(); n++; end
    check("rot2_win_row", 64'(win_row), 64'd2);
    n = 0;
    while (!win_valid && n < 300) begin step(); n++; end
    check("rot2_r1_c0", 64'(rdata1[0 +: PIX_W]), 64'h301);

    n = 0;
    while (!(reg_sel == 3'b100 && win_row == 8'd3) && n < 600) begin step(); n++; end
    check("bot_win_row", 64'(win_row), 64'd3);
    check("bot_zero_cycle", 64'(pix_ready | win_valid), 64'd0);
    step();
    check("bot_sweep_after_one", 64'(win_valid), 64'd1);
    check("bot_reg_zero", 64'(rdata2 == '0), 64'd1);
    n = 0;
    while (!frame_done && n < 300) begin step(); n++; end
    check("done_pulse", 64'(frame_done), 64'd1);
    step();
    check("done_clear", 64'(frame_done), 64'd0);
    check("done_sel_zero", 64'(reg_sel), 64'd0);
    check("done_idle", 64'(win_valid | pix_ready), 64'd0);

    pidx = 0; pix_in = pix_of(0);
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(pix_ready && col_cnt == 8'd100) && n < 200) begin step(); n++; end
    check("rst_reach_col100", 64'(col_cnt), 64'd100);
    rst = 1'b1;
    step();
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_reg_sel", 64'(reg_sel), 64'd0);
    check("rst_col_cnt", 64'(col_cnt), 64'd0);
    check("rst_win_row", 64'(win_row), 64'd0);
    check("rst_win_valid", 64'(win_valid), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_rows_zero", 64'(rdata0 == '0 && rdata1 == '0 && rdata2 == '0), 64'd1);
    rst = 1'b0;
    pidx = 0; pix_in = pix_of(0);
    step();
    check("rst_stays_idle", 64'(pix_ready), 64'd0);

    start = 1'b1; step(); start = 1'b0;
    lat = 0;
    while (!win_valid && lat < 600) begin step(); lat++; end
    check("refill_latency", 64'(lat), 64'd513);
    check("refill_r1_c0", 64'(rdata1[0 +: PIX_W]), 64'h001);
    n = 0;
    while (!frame_done && n < 3000) begin step(); n++; end
    check("refill_frame_done", 64'(frame_done), 64'd1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
